// File: rtl/i2c_bus_frontend.sv
// I2C line conditioner: two-flop synchronizers, per-line glitch filters, SCL edge and
// START/STOP strobes, bus-busy tracking and an SCL-stuck-low timeout.
module i2c_bus_frontend #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned TOUT_W   = 16,
    parameter int unsigned TOUT_CYC = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCL,
    input  logic iSDA,
    output logic oSCL_f,
    output logic oSDA_f,
    output logic oSCL_rise,
    output logic oSCL_fall,
    output logic oSTART,
    output logic oSTOP,
    output logic oBUSY,
    output logic oTIMEOUT
);

    localparam logic [3:0]        FiltMax = 4'(FILT_LEN - 1);
    localparam logic [TOUT_W-1:0] ToutMax = TOUT_W'(TOUT_CYC - 1);

    // Index [0] is the first synchronizer stage, [1] the usable sync value.
    logic [1:0]        scl_sync_q, sda_sync_q;
    logic [3:0]        scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic              scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic              scl_fd_q, sda_fd_q;
    logic              rise_q, rise_d, fall_q, fall_d;
    logic              start_q, start_d, stop_q, stop_d;
    logic              busy_q, busy_d;
    logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
    logic              tout;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_fd_q   <= 1'b1;
            sda_fd_q   <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            tout_cnt_q <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], iSDA};
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_fd_q   <= scl_f_q;
            sda_fd_q   <= sda_f_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            tout_cnt_q <= tout_cnt_d;
        end
    end

    // Filter: a line only moves after FILT_LEN consecutive mismatching sync samples.
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        if (scl_sync_q[1] != scl_f_q) begin
            if (scl_cnt_q == FiltMax) begin
                scl_f_d = scl_sync_q[1];
            end else begin
                scl_cnt_d = scl_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (sda_sync_q[1] != sda_f_q) begin
            if (sda_cnt_q == FiltMax) begin
                sda_f_d = sda_sync_q[1];
            end else begin
                sda_cnt_d = sda_cnt_q + 4'd1;
            end
        end
    end

    // START/STOP require SCL high on both sides, so a same-cycle SCL change suppresses them.
    always_comb begin
        rise_d  = scl_f_q & ~scl_fd_q;
        fall_d  = ~scl_f_q & scl_fd_q;
        start_d = scl_f_q & scl_fd_q & ~sda_f_q & sda_fd_q;
        stop_d  = scl_f_q & scl_fd_q & sda_f_q & ~sda_fd_q;
    end

    always_comb begin
        tout       = busy_q & ~scl_f_q & (tout_cnt_q == ToutMax);
        tout_cnt_d = '0;
        if (busy_q && !scl_f_q && !tout) begin
            tout_cnt_d = tout_cnt_q + 1'b1;
        end
        busy_d = busy_q;
        if (start_d) begin
            busy_d = 1'b1;
        end else if (stop_d || tout) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        oSCL_f    = scl_f_q;
        oSDA_f    = sda_f_q;
        oSCL_rise = rise_q;
        oSCL_fall = fall_q;
        oSTART    = start_q;
        oSTOP     = stop_q;
        oBUSY     = busy_q;
        oTIMEOUT  = tout;
    end

endmodule
